keypad_scan: RTL and testbench

Matrix keypad scanner that drives the key matrix rows, samples the columns, debounces every key per scan frame, and emits one-cycle press pulses plus a key code. It sits directly upstream of the object counter stage: its `key_press` bits replace the raw `btn` inputs to `chooseadder`, and its `row_n` output drives the keypad row pins.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_debounce.sv | 88 ++++++++
 rtl/keypad_scan.sv | 125 ++++++++++++
 tb/tb_keypad_scan.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key index arithmetic and the
// mapping from keypad keys to the downstream object-counter slots.
package keypad_pkg;

  typedef logic [3:0] obj_slot_t;

  // Keys 0..9 drive the counter stage's object slots in order.
  localparam obj_slot_t OBJ_SLOT [10] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
  };

  // Width of a key index; a single-key matrix still needs one bit.
  function automatic int key_idx_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Linear key index for a matrix position.
  function automatic int key_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-key frame debouncer: DEB_FRAMES-deep history, debounced level and
// press pulse. Optional auto-repeat counter when KEYPAD_AUTOREPEAT_EN is
// defined; without it each debounced press gives exactly one pulse.
module keypad_debounce #(
  parameter int DEB_FRAMES = 3
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_FRAMES = 16
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic frame_tick,
  input  logic sample,
  output logic state,
  output logic press,
  output logic fire
);

  logic [DEB_FRAMES-1:0] hist;
  logic [DEB_FRAMES-1:0] hist_nxt;
  logic all_one;
  logic all_zero;
  logic rise;
  logic rpt;

  assign hist_nxt = {hist[DEB_FRAMES-2:0], sample};
  assign all_one  = &hist_nxt;
  assign all_zero = ~|hist_nxt;
  assign rise     = frame_tick && all_one && !state;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int CW = $clog2(2 * REPEAT_FRAMES + 1);
  localparam logic [CW-1:0] RPT_FIRST = CW'(2 * REPEAT_FRAMES);
  localparam logic [CW-1:0] RPT_NEXT  = CW'(REPEAT_FRAMES);

  logic [CW-1:0] rcnt;

  // A repeat fires when the down-counter is at 1 and the key is still held.
  assign rpt = frame_tick && state && !all_zero && (rcnt == CW'(1));

  // Frames remaining until the next repeat pulse; idle at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rcnt <= '0;
    end else if (clr) begin
      rcnt <= '0;
    end else if (frame_tick) begin
      if (rise)
        rcnt <= RPT_FIRST;
      else if (!state || all_zero)
        rcnt <= '0;
      else if (rcnt == CW'(1))
        rcnt <= RPT_NEXT;
      else if (rcnt != '0)
        rcnt <= rcnt - 1'b1;
    end
  end
`else
  assign rpt = 1'b0;
`endif

  // Combinational pulse request, also used by the top for key_code.
  assign fire = !clr && (rise || rpt);

  // History shift and debounced level update once per frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist  <= '0;
      state <= 1'b0;
      press <= 1'b0;
    end else if (clr) begin
      hist  <= '0;
      state <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= fire;
      if (frame_tick) begin
        hist <= hist_nxt;
        if (all_one)
          state <= 1'b1;
        else if (all_zero)
          state <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: drives one row low at a time, samples the
// synchronized columns at the end of each row dwell, and debounces every key
// per frame. Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat).
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int DEB_FRAMES    = 3,
  parameter int REPEAT_FRAMES = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                scan_en,
  input  logic [COLS-1:0]                     col_n,
  output logic [ROWS-1:0]                     row_n,
  output logic [ROWS*COLS-1:0]                key_state,
  output logic [ROWS*COLS-1:0]                key_press,
  output logic [key_idx_w(ROWS, COLS)-1:0]    key_code,
  output logic                                key_valid
);

  localparam int NK = ROWS * COLS;
  localparam int KW = key_idx_w(ROWS, COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(SCAN_DIV - 1);

  if (SCAN_DIV < 4 || DEB_FRAMES < 2 || DEB_FRAMES > 8 || REPEAT_FRAMES < 1) begin : g_bad_param
    $error("keypad_scan: parameter out of range");
  end

  logic [COLS-1:0] col_s1;
  logic [COLS-1:0] col_s2;
  logic            active;
  logic [RW-1:0]   r;
  logic [DW-1:0]   d;
  logic [NK-1:0]   snap;
  logic            frame_tick;
  logic [NK-1:0]   fire_v;
  logic [KW-1:0]   code_nxt;

  // Two-flop synchronizer; idle columns are pulled high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // Row released entirely while disabled; otherwise one-hot-low on row r.
  assign row_n = active ? ~(ROWS'(1) << r) : '1;

  // Row dwell timer, row index, snapshot capture and frame tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active     <= 1'b1;
      r          <= '0;
      d          <= '0;
      snap       <= '0;
      frame_tick <= 1'b0;
    end else if (!scan_en) begin
      active     <= 1'b0;
      r          <= '0;
      d          <= '0;
      snap       <= '0;
      frame_tick <= 1'b0;
    end else begin
      active     <= 1'b1;
      frame_tick <= 1'b0;
      if (d == D_LAST) begin
        snap[key_index(int'(r), 0, COLS) +: COLS] <= ~col_s2;
        d          <= '0;
        r          <= (r == R_LAST) ? '0 : r + 1'b1;
        frame_tick <= (r == R_LAST);
      end else begin
        d <= d + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NK; k++) begin : g_key
    keypad_debounce #(
      .DEB_FRAMES    (DEB_FRAMES)
`ifdef KEYPAD_AUTOREPEAT_EN
      , .REPEAT_FRAMES (REPEAT_FRAMES)
`endif
    ) u_deb (
      .clk        (clk),
      .rstn       (rstn),
      .clr        (!scan_en),
      .frame_tick (frame_tick),
      .sample     (snap[k]),
      .state      (key_state[k]),
      .press      (key_press[k]),
      .fire       (fire_v[k])
    );
  end

  // Lowest-numbered key among this cycle's pulse requests.
  always_comb begin
    code_nxt = '0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (fire_v[k])
        code_nxt = KW'(k);
    end
  end

  // Code and qualifier registered alongside the per-key press flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_code  <= code_nxt;
      key_valid <= |fire_v;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: physical matrix model drives col_n
// from row_n and the held key set; a frame-level debounce model predicts
// pulses, codes and debounced levels.
module tb_keypad_scan;

  localparam int ROWS          = 4;
  localparam int COLS          = 4;
  localparam int SCAN_DIV      = 8;
  localparam int DEB_FRAMES    = 3;
  localparam int REPEAT_FRAMES = 4;
  localparam int NK            = ROWS * COLS;
  localparam int FRAME         = ROWS * SCAN_DIV;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            scan_en = 1'b1;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [NK-1:0]   key_state;
  logic [NK-1:0]   key_press;
  logic [3:0]      key_code;
  logic            key_valid;

  logic [NK-1:0]   keys = '0;

  int n_tests = 0;
  int n_fail  = 0;

  int prs_run [NK];
  int rel_run [NK];
  int held    [NK];
  bit st      [NK];
  int frame_no;
  int pulse_frames [$];
  logic [NK-1:0] last_press;
  logic [3:0]    last_code;

  always #5 clk = ~clk;

  keypad_scan #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SCAN_DIV      (SCAN_DIV),
    .DEB_FRAMES    (DEB_FRAMES),
    .REPEAT_FRAMES (REPEAT_FRAMES)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .scan_en   (scan_en),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_state (key_state),
    .key_press (key_press),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  // A pressed key pulls its column low whenever its row is driven low.
  always_comb begin
    col_n = '1;
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        if (!row_n[rr] && keys[rr*COLS + cc]) col_n[cc] = 1'b0;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NK; k++) begin
      prs_run[k] = 0;
      rel_run[k] = 0;
      held[k]    = 0;
      st[k]      = 1'b0;
    end
    frame_no = 0;
  endtask

  // One frame of the debounce rules, in terms of run lengths of samples.
  task automatic model_frame(input logic [NK-1:0] pat, output logic [NK-1:0] ep,
                             output logic [3:0] ec, output logic [NK-1:0] est);
    ep = '0; ec = '0; est = '0;
    for (int k = 0; k < NK; k++) begin
      if (pat[k]) begin prs_run[k]++; rel_run[k] = 0; end
      else begin rel_run[k]++; prs_run[k] = 0; end
      if (!st[k] && prs_run[k] >= DEB_FRAMES) begin
        st[k] = 1'b1; ep[k] = 1'b1; held[k] = 0;
      end else if (st[k] && rel_run[k] >= DEB_FRAMES) begin
        st[k] = 1'b0;
      end else if (st[k]) begin
        held[k]++;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (held[k] >= 2*REPEAT_FRAMES && (held[k] - 2*REPEAT_FRAMES) % REPEAT_FRAMES == 0)
          ep[k] = 1'b1;
`endif
      end
      est[k] = st[k];
    end
    for (int k = NK - 1; k >= 0; k--) if (ep[k]) ec = 4'(k);
  endtask

  // Called #1 after a posedge; the window covers the pulse ending this frame.
  task automatic run_frame(input logic [NK-1:0] pat);
    logic [NK-1:0] ep, est, obs_p;
    logic [3:0] ec, obs_c;
    int npulse, badv;
    keys = pat;
    frame_no++;
    model_frame(pat, ep, ec, est);
    npulse = 0; badv = 0; obs_p = '0; obs_c = '0;
    repeat (FRAME) begin
      @(posedge clk); #1;
      if (key_press != '0) begin
        npulse++;
        obs_p = key_press;
        obs_c = key_code;
        pulse_frames.push_back(frame_no);
      end
      if (key_valid !== (|key_press)) badv++;
    end
    check_val("pulse_cnt", 32'(npulse), (ep != '0) ? 32'd1 : 32'd0);
    check_val("press_vec", 32'(obs_p), 32'(ep));
    if (ep != '0) check_val("key_code", 32'(obs_c), 32'(ec));
    check_val("valid_qual", 32'(badv), 32'd0);
    check_val("key_state", 32'(key_state), 32'(est));
    last_press = obs_p;
    last_code  = obs_c;
  endtask

  task automatic hold(input logic [NK-1:0] pat, input int n);
    for (int i = 0; i < n; i++) run_frame(pat);
  endtask

  // Enable (or reset release) applied #1 after a posedge: align to frame grid.
  task automatic begin_epoch();
    repeat (2) @(posedge clk);
    #1;
    model_clear();
  endtask

  // Called #1 after a posedge: reset mid-cycle, then check row restart.
  task automatic reset_check();
    #2 rstn = 1'b0;
    #1;
    check_val("rst_row_n", 32'(row_n), 32'hE);
    check_val("rst_state", 32'(key_state), 32'd0);
    check_val("rst_press", 32'(key_press), 32'd0);
    check_val("rst_code", 32'(key_code), 32'd0);
    check_val("rst_valid", 32'(key_valid), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check_val("row0_dwell", 32'(row_n), 32'hE);
    @(posedge clk); #1;
    check_val("row1_start", 32'(row_n), 32'hD);
    scan_en = 1'b0;
    @(posedge clk); #1;
    scan_en = 1'b1;
    begin_epoch();
  endtask

  initial begin
    logic [NK-1:0] pat;
    int exp_rep [$];
    @(posedge clk); #1;
    reset_check();

    // Single steady press of key 6.
    pulse_frames.delete();
    hold(NK'(1) << 6, 6);
    check_val("single_cnt", 32'(pulse_frames.size()), 32'd1);
    check_val("single_frame", (pulse_frames.size() > 0) ? 32'(pulse_frames[0]) : 32'hFFFF, 32'd3);
    hold('0, 4);

    // Bounce: alternating frames never qualify.
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? (NK'(1) << 6) : '0);
    check_val("bounce_state", 32'(key_state[6]), 32'd0);
    hold('0, 2);
    hold(NK'(1) << 6, 4);
    pulse_frames.delete();
    hold('0, 4);
    check_val("release_nopulse", 32'(pulse_frames.size()), 32'd0);

    // Simultaneous press of keys 9 and 3.
    pulse_frames.delete();
    hold((NK'(1) << 9) | (NK'(1) << 3), 3);
    check_val("simul_vec", 32'(last_press), 32'h0208);
    check_val("simul_code", 32'(last_code), 32'd3);
    hold('0, 4);

    // Disable while key 6 is held, then re-enable.
    hold(NK'(1) << 6, 4);
    repeat (10) @(posedge clk);
    #1 scan_en = 1'b0;
    @(posedge clk); #1;
    check_val("dis_row_n", 32'(row_n), 32'hF);
    check_val("dis_state", 32'(key_state), 32'd0);
    check_val("dis_press", 32'(key_press), 32'd0);
    repeat (3) @(posedge clk);
    #1 scan_en = 1'b1;
    begin_epoch();
    pulse_frames.delete();
    hold(NK'(1) << 6, 4);
    check_val("reen_frame", (pulse_frames.size() > 0) ? 32'(pulse_frames[0]) : 32'hFFFF, 32'd3);
    hold('0, 4);

    // Long hold of key 0: repeat pulses only with the auto-repeat build.
    pulse_frames.delete();
    frame_no = 0;
    hold(NK'(1), 20);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_rep = '{3, 11, 15, 19};
`else
    exp_rep = '{3};
`endif
    check_val("repeat_cnt", 32'(pulse_frames.size()), 32'(exp_rep.size()));
    for (int i = 0; i < exp_rep.size(); i++)
      check_val("repeat_frame", (i < pulse_frames.size()) ? 32'(pulse_frames[i]) : 32'hFFFF,
                32'(exp_rep[i]));
    hold('0, 4);

    // Reset mid-scan with a key held.
    hold(NK'(1) << 5, 4);
    repeat (13) @(posedge clk);
    #1;
    reset_check();

    // Random key activity.
    pat = '0;
    keys = '0;
    for (int f = 0; f < 60; f++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 4) == 0) pat[k] = ~pat[k];
      run_frame(pat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
